// File: rtl/alu_reservation_station_pkg.sv
// Shared types for the Tomasulo ALU path (package tomasula_types).
//   RS_DEPTH / TAG_W   : default reservation-station depth and tag width
//   op_t               : ALU op class (ARITH, or OTHER which the ALU treats as add)
//   alu_word           : word handed from the reservation station to the ALU
//   cdb_data_t         : common data bus broadcast
//   rs_operand_t       : per-operand {rdy, val, tag}
//   rs_entry_t         : reservation-station entry
//   capture()          : applies a CDB broadcast to one waiting operand
package tomasula_types;

  localparam int unsigned RS_DEPTH = 4;
  localparam int unsigned TAG_W    = 3;

  typedef enum logic {
    OP_ARITH = 1'b0,
    OP_OTHER = 1'b1
  } op_t;

  typedef struct packed {
    op_t              op;
    logic [31:0]      src1_data;
    logic [31:0]      src2_data;
    logic [2:0]       funct3;
    logic             funct7;
    logic [TAG_W-1:0] tag;
    logic             load;
  } alu_word;

  typedef struct packed {
    logic             req;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } cdb_data_t;

  typedef struct packed {
    logic             rdy;
    logic [31:0]      val;
    logic [TAG_W-1:0] tag;
  } rs_operand_t;

  typedef struct packed {
    logic             busy;
    op_t              op;
    logic [2:0]       funct3;
    logic             funct7;
    logic [TAG_W-1:0] dest_tag;
    rs_operand_t      src1;
    rs_operand_t      src2;
  } rs_entry_t;

  function automatic rs_operand_t capture(input rs_operand_t opnd, input cdb_data_t cdb);
    rs_operand_t res;
    res = opnd;
    if (!opnd.rdy && cdb.req && (opnd.tag == cdb.tag)) begin
      res.rdy = 1'b1;
      res.val = cdb.data;
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_reservation_station_select.sv
// rs_select: picks one ready reservation-station entry per cycle.
//   ready_i : per-entry ready vector
//   age_i   : per-entry age (only with RS_AGE_ORDER_EN; larger = older)
//   grant_o : one-hot grant of the chosen entry ('0 when nothing is ready)
//   valid_o : any entry ready
// RS_AGE_ORDER_EN defined: oldest ready entry wins. Otherwise lowest index wins.
module rs_select #(
  parameter int unsigned DEPTH = 4
) (
  input  logic [DEPTH-1:0]                    ready_i,
`ifdef RS_AGE_ORDER_EN
  input  logic [DEPTH-1:0][$clog2(DEPTH)-1:0] age_i,
`endif
  output logic [DEPTH-1:0]                    grant_o,
  output logic                                valid_o
);

  logic found;
`ifdef RS_AGE_ORDER_EN
  logic [$clog2(DEPTH)-1:0] best;
`endif

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
`ifdef RS_AGE_ORDER_EN
    best    = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef RS_AGE_ORDER_EN
      if (ready_i[i] && (!found || (age_i[i] > best))) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        best       = age_i[i];
        found      = 1'b1;
      end
`else
      if (ready_i[i] && !found) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
`endif
    end
  end

  assign valid_o = |ready_i;

endmodule

// File: rtl/alu_reservation_station.sv
// Tomasulo reservation station in front of the combinational ALU.
// Buffers dispatched ops, snoops the CDB for missing operands and issues one
// fully-ready op per cycle as a tomasula_types::alu_word.
//   clk, rst (async, active-high), flush (sync squash of all entries)
//   disp_*  : dispatch request/handshake, op fields and two source operands
//   cdb_*   : CDB broadcast (req, tag, data)
//   issue_* : valid/ready handshake and the combinational issue word
// Optional: RS_AGE_ORDER_EN selects oldest-ready issue instead of lowest index.
module alu_reservation_station #(
  parameter int unsigned DEPTH = tomasula_types::RS_DEPTH,
  parameter int unsigned TAG_W = tomasula_types::TAG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  disp_valid,
  output logic                  disp_ready,
  input  tomasula_types::op_t   disp_op,
  input  logic [2:0]            disp_funct3,
  input  logic                  disp_funct7,
  input  logic [TAG_W-1:0]      disp_dest_tag,
  input  logic                  disp_src1_rdy,
  input  logic [31:0]           disp_src1,
  input  logic [TAG_W-1:0]      disp_src1_tag,
  input  logic                  disp_src2_rdy,
  input  logic [31:0]           disp_src2,
  input  logic [TAG_W-1:0]      disp_src2_tag,
  input  logic                  cdb_req,
  input  logic [TAG_W-1:0]      cdb_tag,
  input  logic [31:0]           cdb_data,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output tomasula_types::alu_word issue_word
);

  import tomasula_types::*;

  rs_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [DEPTH-1:0]      busy_vec, ready_vec, grant, free_onehot;
  logic                  free_found, do_disp, do_issue;
  cdb_data_t             cdb;
  rs_entry_t             new_ent;

`ifdef RS_AGE_ORDER_EN
  localparam int unsigned AW = $clog2(DEPTH);
  logic [DEPTH-1:0][AW-1:0] age_q, age_d;
  logic [AW-1:0]            sel_age;
`endif

  assign cdb = '{req: cdb_req, tag: cdb_tag, data: cdb_data};

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      busy_vec[i]  = ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy && ent_q[i].src1.rdy && ent_q[i].src2.rdy;
    end
  end

  // Based on the registered busy bits only: a slot freed by this cycle's issue
  // is not offered to dispatch until the next cycle.
  assign disp_ready = ~&busy_vec;

  always_comb begin
    free_onehot = '0;
    free_found  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!busy_vec[i] && !free_found) begin
        free_onehot[i] = 1'b1;
        free_found     = 1'b1;
      end
    end
  end

  rs_select #(.DEPTH(DEPTH)) u_select (
    .ready_i (ready_vec),
`ifdef RS_AGE_ORDER_EN
    .age_i   (age_q),
`endif
    .grant_o (grant),
    .valid_o (issue_valid)
  );

  // grant is one-hot and non-zero exactly when issue_valid is high.
  always_comb begin
    issue_word = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        issue_word.op        = ent_q[i].op;
        issue_word.src1_data = ent_q[i].src1.val;
        issue_word.src2_data = ent_q[i].src2.val;
        issue_word.funct3    = ent_q[i].funct3;
        issue_word.funct7    = ent_q[i].funct7;
        issue_word.tag       = ent_q[i].dest_tag;
        issue_word.load      = 1'b1;
      end
    end
  end

  assign do_disp  = disp_valid && disp_ready;
  assign do_issue = issue_valid && issue_ready;

  always_comb begin
    // Dispatched operands also see the same-cycle broadcast (bypass).
    new_ent          = '0;
    new_ent.busy     = 1'b1;
    new_ent.op       = disp_op;
    new_ent.funct3   = disp_funct3;
    new_ent.funct7   = disp_funct7;
    new_ent.dest_tag = disp_dest_tag;
    new_ent.src1     = capture('{rdy: disp_src1_rdy, val: disp_src1, tag: disp_src1_tag}, cdb);
    new_ent.src2     = capture('{rdy: disp_src2_rdy, val: disp_src2, tag: disp_src2_tag}, cdb);
  end

  always_comb begin
    ent_d = ent_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_q[i].busy) begin
        ent_d[i].src1 = capture(ent_q[i].src1, cdb);
        ent_d[i].src2 = capture(ent_q[i].src2, cdb);
      end
      if (do_issue && grant[i]) begin
        ent_d[i] = '0;
      end
      if (do_disp && free_onehot[i]) begin
        ent_d[i] = new_ent;
      end
    end
    if (flush) begin
      ent_d = '0;
    end
  end

`ifdef RS_AGE_ORDER_EN
  // age = number of busy entries dispatched after this one (oldest is largest).
  always_comb begin
    sel_age = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel_age = age_q[i];
      end
    end
    age_d = age_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_q[i].busy) begin
        if (do_disp) begin
          age_d[i] = age_d[i] + 1'b1;
        end
        if (do_issue && (age_q[i] > sel_age)) begin
          age_d[i] = age_d[i] - 1'b1;
        end
      end
      if ((do_issue && grant[i]) || (do_disp && free_onehot[i])) begin
        age_d[i] = '0;
      end
    end
    if (flush) begin
      age_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
module tb_alu_reservation_station;
  import tomasula_types::*;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst, flush, disp_valid, disp_ready;
  op_t         disp_op;
  logic [2:0]  disp_funct3;
  logic        disp_funct7;
  logic [2:0]  disp_dest_tag;
  logic        disp_src1_rdy, disp_src2_rdy;
  logic [31:0] disp_src1, disp_src2;
  logic [2:0]  disp_src1_tag, disp_src2_tag;
  logic        cdb_req;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        issue_valid, issue_ready;
  alu_word     issue_word;

  int n_vec = 0;
  int n_err = 0;

  alu_reservation_station #(.DEPTH(4), .TAG_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_funct3(disp_funct3), .disp_funct7(disp_funct7), .disp_dest_tag(disp_dest_tag),
    .disp_src1_rdy(disp_src1_rdy), .disp_src1(disp_src1), .disp_src1_tag(disp_src1_tag),
    .disp_src2_rdy(disp_src2_rdy), .disp_src2(disp_src2), .disp_src2_tag(disp_src2_tag),
    .cdb_req(cdb_req), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_word(issue_word)
  );

  always #5 clk = ~clk;

  // Reference model: a slot array of pending ops.
  bit          m_busy[D];
  bit          m_r1[D], m_r2[D];
  logic [31:0] m_v1[D], m_v2[D];
  logic [2:0]  m_t1[D], m_t2[D], m_dt[D], m_f3[D];
  logic        m_f7[D];
  op_t         m_op[D];
  bit          e_dr, e_iv;
  int          e_idx;
  alu_word     e_w;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_word(input string nm, input alu_word got, input alu_word exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < D; i++) m_busy[i] = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
    e_dr = 1'b0;
    e_iv = 1'b0;
    e_idx = 0;
    for (int i = 0; i < D; i++) if (!m_busy[i]) e_dr = 1'b1;
    for (int i = D - 1; i >= 0; i--)
      if (m_busy[i] && m_r1[i] && m_r2[i]) begin e_iv = 1'b1; e_idx = i; end
    e_w = '0;
    if (e_iv) begin
      e_w.op = m_op[e_idx];       e_w.src1_data = m_v1[e_idx];
      e_w.src2_data = m_v2[e_idx]; e_w.funct3 = m_f3[e_idx];
      e_w.funct7 = m_f7[e_idx];   e_w.tag = m_dt[e_idx];
      e_w.load = 1'b1;
    end
    chk("disp_ready", 32'(disp_ready), 32'(e_dr));
    chk("issue_valid", 32'(issue_valid), 32'(e_iv));
    chk_word("issue_word", issue_word, e_w);
  endtask

  task automatic advance();
    bit take, dd;
    int fi;
    take = e_iv && issue_ready;
    dd   = disp_valid && e_dr;
    fi   = -1;
    for (int i = D - 1; i >= 0; i--) if (!m_busy[i]) fi = i;
    if (rst || flush) begin
      model_clear();
    end else begin
      for (int i = 0; i < D; i++) begin
        if (m_busy[i] && cdb_req && !m_r1[i] && m_t1[i] == cdb_tag) begin m_r1[i] = 1'b1; m_v1[i] = cdb_data; end
        if (m_busy[i] && cdb_req && !m_r2[i] && m_t2[i] == cdb_tag) begin m_r2[i] = 1'b1; m_v2[i] = cdb_data; end
      end
      if (take) m_busy[e_idx] = 1'b0;
      if (dd && fi >= 0) begin
        m_busy[fi] = 1'b1;
        m_op[fi] = disp_op; m_f3[fi] = disp_funct3; m_f7[fi] = disp_funct7; m_dt[fi] = disp_dest_tag;
        m_t1[fi] = disp_src1_tag; m_t2[fi] = disp_src2_tag;
        m_r1[fi] = disp_src1_rdy || (cdb_req && cdb_tag == disp_src1_tag);
        m_v1[fi] = disp_src1_rdy ? disp_src1 : cdb_data;
        m_r2[fi] = disp_src2_rdy || (cdb_req && cdb_tag == disp_src2_tag);
        m_v2[fi] = disp_src2_rdy ? disp_src2 : cdb_data;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ir);
    flush = 1'b0; disp_valid = 1'b0; cdb_req = 1'b0; issue_ready = ir;
    disp_op = OP_ARITH; disp_funct3 = 3'd0; disp_funct7 = 1'b0; disp_dest_tag = 3'd0;
    disp_src1_rdy = 1'b0; disp_src1 = '0; disp_src1_tag = 3'd0;
    disp_src2_rdy = 1'b0; disp_src2 = '0; disp_src2_tag = 3'd0;
    cdb_tag = 3'd0; cdb_data = '0;
  endtask

  task automatic disp(input logic r1, input logic [31:0] v1, input logic [2:0] t1,
                      input logic r2, input logic [31:0] v2, input logic [2:0] t2,
                      input logic [2:0] dt);
    disp_valid = 1'b1; disp_dest_tag = dt;
    disp_src1_rdy = r1; disp_src1 = v1; disp_src1_tag = t1;
    disp_src2_rdy = r2; disp_src2 = v2; disp_src2_tag = t2;
  endtask

  typedef struct {
    logic dv; logic s1r; logic [31:0] s1; logic [2:0] s1t;
    logic s2r; logic [31:0] s2; logic [2:0] s2t; logic [2:0] dt;
    logic cr; logic [2:0] ct; logic [31:0] cd; logic ir;
    logic e_iv; logic e_dr; logic [31:0] e_s1; logic [31:0] e_s2; logic [2:0] e_tag;
  } vec_t;

  vec_t tbl[11];
  alu_word w5;

  initial begin
    // dv s1r s1 s1t s2r s2 s2t dt | cr ct cd | ir | e_iv e_dr e_s1 e_s2 e_tag
    tbl[0]  = '{1'b1, 1'b1, 32'd5, 3'd0, 1'b1, 32'd7, 3'd0, 3'd2, 1'b0, 3'd0, 32'd0,    1'b1, 1'b0, 1'b1, 32'd0,    32'd0, 3'd0};
    tbl[1]  = '{1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0,    1'b1, 1'b1, 1'b1, 32'd5,    32'd7, 3'd2};
    tbl[2]  = '{1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0,    1'b1, 1'b0, 1'b1, 32'd0,    32'd0, 3'd0};
    tbl[3]  = '{1'b1, 1'b0, 32'd0, 3'd3, 1'b1, 32'd1, 3'd0, 3'd5, 1'b0, 3'd0, 32'd0,    1'b1, 1'b0, 1'b1, 32'd0,    32'd0, 3'd0};
    tbl[4]  = '{1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0,    1'b1, 1'b0, 1'b1, 32'd0,    32'd0, 3'd0};
    tbl[5]  = '{1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b1, 3'd3, 32'h10,   1'b1, 1'b0, 1'b1, 32'd0,    32'd0, 3'd0};
    tbl[6]  = '{1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0,    1'b1, 1'b1, 1'b1, 32'h10,   32'd1, 3'd5};
    tbl[7]  = '{1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0,    1'b1, 1'b0, 1'b1, 32'd0,    32'd0, 3'd0};
    tbl[8]  = '{1'b1, 1'b1, 32'd2, 3'd0, 1'b0, 32'd0, 3'd4, 3'd6, 1'b1, 3'd4, 32'd9,    1'b1, 1'b0, 1'b1, 32'd0,    32'd0, 3'd0};
    tbl[9]  = '{1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0,    1'b1, 1'b1, 1'b1, 32'd2,    32'd9, 3'd6};
    tbl[10] = '{1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0,    1'b1, 1'b0, 1'b1, 32'd0,    32'd0, 3'd0};

    model_clear();
    idle(1'b0);
    rst = 1'b1;
    sample();
    chk("reset_word", 32'(issue_word != '0), 32'd0);
    advance();
    rst = 1'b0;

    // Directed vectors: ready dispatch, CDB wake-up, dispatch/CDB bypass.
    for (int k = 0; k < 11; k++) begin
      idle(tbl[k].ir);
      if (tbl[k].dv) disp(tbl[k].s1r, tbl[k].s1, tbl[k].s1t, tbl[k].s2r, tbl[k].s2, tbl[k].s2t, tbl[k].dt);
      cdb_req = tbl[k].cr; cdb_tag = tbl[k].ct; cdb_data = tbl[k].cd;
      sample();
      chk("tbl_issue_valid", 32'(issue_valid), 32'(tbl[k].e_iv));
      chk("tbl_disp_ready", 32'(disp_ready), 32'(tbl[k].e_dr));
      if (tbl[k].e_iv) begin
        chk("tbl_src1", issue_word.src1_data, tbl[k].e_s1);
        chk("tbl_src2", issue_word.src2_data, tbl[k].e_s2);
        chk("tbl_tag", 32'(issue_word.tag), 32'(tbl[k].e_tag));
      end
      advance();
    end

    // Fill all entries with waiting ops; extra dispatch while full is ignored.
    for (int k = 0; k < D; k++) begin
      idle(1'b1);
      disp(1'b0, 32'd0, 3'(k), 1'b1, 32'd100, 3'd0, 3'(k + 4));
      sample(); advance();
    end
    idle(1'b1);
    disp(1'b1, 32'd1, 3'd0, 1'b1, 32'd1, 3'd0, 3'd7);
    sample();
    chk("full_disp_ready", 32'(disp_ready), 32'd0);
    advance();
    idle(1'b1);
    cdb_req = 1'b1; cdb_tag = 3'd2; cdb_data = 32'h22;
    sample();
    chk("full_no_issue", 32'(issue_valid), 32'd0);
    advance();
    idle(1'b1);
    sample();
    chk("full_issue_tag", 32'(issue_word.tag), 32'd6);
    chk("full_issue_src1", issue_word.src1_data, 32'h22);
    chk("full_ready_same_cycle", 32'(disp_ready), 32'd0);
    advance();
    idle(1'b1);
    sample();
    chk("full_ready_after", 32'(disp_ready), 32'd1);
    advance();
    idle(1'b1); flush = 1'b1;
    sample(); advance();

    // Stall for 3 cycles: issue word held, then accepted and freed.
    idle(1'b0);
    disp_op = OP_OTHER; disp_funct3 = 3'b101; disp_funct7 = 1'b1;
    disp(1'b1, 32'hAAAA, 3'd0, 1'b1, 32'h5555, 3'd0, 3'd1);
    sample(); advance();
    w5 = '0;
    w5.op = OP_OTHER; w5.src1_data = 32'hAAAA; w5.src2_data = 32'h5555;
    w5.funct3 = 3'b101; w5.funct7 = 1'b1; w5.tag = 3'd1; w5.load = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle(1'b0);
      sample();
      chk_word("stall_word", issue_word, w5);
      advance();
    end
    idle(1'b1);
    sample();
    chk("stall_accept_valid", 32'(issue_valid), 32'd1);
    advance();
    idle(1'b0);
    sample();
    chk("stall_freed", 32'(issue_valid), 32'd0);
    advance();

    // Flush with three busy entries and a same-cycle ready dispatch.
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      disp(1'b0, 32'd0, 3'd5, 1'b1, 32'd3, 3'd0, 3'(k));
      sample(); advance();
    end
    idle(1'b1);
    flush = 1'b1;
    disp(1'b1, 32'd4, 3'd0, 1'b1, 32'd4, 3'd0, 3'd3);
    cdb_req = 1'b1; cdb_tag = 3'd5; cdb_data = 32'h55;
    sample(); advance();
    idle(1'b1);
    sample();
    chk("flush_issue_valid", 32'(issue_valid), 32'd0);
    chk("flush_disp_ready", 32'(disp_ready), 32'd1);
    advance();

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      idle(1'b0);
      issue_ready   = ($urandom_range(0, 9) < 7);
      flush         = ($urandom_range(0, 99) < 3);
      disp_valid    = $urandom_range(0, 1) == 1;
      disp_op       = op_t'($urandom_range(0, 1));
      disp_funct3   = 3'($urandom());
      disp_funct7   = 1'($urandom());
      disp_dest_tag = 3'($urandom());
      disp_src1_rdy = $urandom_range(0, 1) == 1;
      disp_src1     = $urandom();
      disp_src1_tag = 3'($urandom());
      disp_src2_rdy = $urandom_range(0, 1) == 1;
      disp_src2     = $urandom();
      disp_src2_tag = 3'($urandom());
      cdb_req       = ($urandom_range(0, 9) < 4);
      cdb_tag       = 3'($urandom());
      cdb_data      = $urandom();
      sample(); advance();
    end

    // Asynchronous reset mid-stream.
    idle(1'b0); flush = 1'b1;
    sample(); advance();
    idle(1'b0);
    disp(1'b1, 32'd8, 3'd0, 1'b1, 32'd9, 3'd0, 3'd4);
    sample(); advance();
    idle(1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(issue_valid), 32'd0);
    chk("async_rst_ready", 32'(disp_ready), 32'd1);
    chk("async_rst_word", 32'(issue_word != '0), 32'd0);
    model_clear();
    sample(); advance();
    rst = 1'b0;
    idle(1'b1);
    sample(); advance();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
